// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand select for the 64-bit ALU.
// Holds one decoded instruction and forwards EX/MEM and MEM/WB results.
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RAW-1:0]  id_rs1,
  input  logic [RAW-1:0]  id_rs2,
  input  logic [RAW-1:0]  id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic [2:0]      id_class,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            exmem_reg_write,
  input  logic            memwb_reg_write,
  input  logic [RAW-1:0]  exmem_rd,
  input  logic [RAW-1:0]  memwb_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [XLEN-1:0] memwb_wdata,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [3:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RAW-1:0]  ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_is_branch,
  output logic            load_use_hazard
);

  localparam logic [2:0] CLS_R  = 3'd0;
  localparam logic [2:0] CLS_I  = 3'd1;
  localparam logic [2:0] CLS_LD = 3'd2;
  localparam logic [2:0] CLS_ST = 3'd3;
  localparam logic [2:0] CLS_BR = 3'd4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            use_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            is_branch;
  } id_ex_t;

  id_ex_t dec;
  id_ex_t ex_d;
  id_ex_t ex_q;
  logic   known;

  always_comb begin
    dec            = '0;
    known          = 1'b1;
    dec.valid      = 1'b1;
    dec.pc         = id_pc;
    dec.rs1_data   = id_rs1_data;
    dec.rs2_data   = id_rs2_data;
    dec.imm        = id_imm;
    dec.rs1        = id_rs1;
    dec.rs2        = id_rs2;
    dec.rd         = id_rd;
    dec.funct3     = id_funct3;
    dec.reg_write  = id_reg_write;
    dec.mem_read   = id_mem_read;
    dec.mem_write  = id_mem_write;
    dec.mem_to_reg = id_mem_to_reg;
    case (id_class)
      CLS_R: dec.alu_op = {id_funct7_5, id_funct3};
      CLS_I: begin
        // only SRAI carries funct7[5] into the opcode
        dec.alu_op  = {id_funct7_5 & (id_funct3 == 3'b101), id_funct3};
        dec.use_imm = 1'b1;
      end
      CLS_LD, CLS_ST: begin
        dec.alu_op  = 4'b0000;
        dec.use_imm = 1'b1;
      end
      CLS_BR: begin
        dec.alu_op    = 4'b1000;
        dec.is_branch = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d = (id_valid && known) ? dec : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  always_comb begin
    fwd_a = ex_q.rs1_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs1) begin
      fwd_a = exmem_result;
    end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs1) begin
      fwd_a = memwb_wdata;
    end
  end

  always_comb begin
    fwd_b = ex_q.rs2_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs2) begin
      fwd_b = exmem_result;
    end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs2) begin
      fwd_b = memwb_wdata;
    end
  end

  logic rs2_used;
  assign rs2_used = (id_class != CLS_I) && (id_class != CLS_LD);

  assign load_use_hazard = id_valid && ex_q.valid && ex_q.mem_read
                        && (ex_q.rd != '0)
                        && ((ex_q.rd == id_rs1)
                         || ((ex_q.rd == id_rs2) && rs2_used));

  assign ex_valid      = ex_q.valid;
  assign ex_alu_a      = fwd_a;
  assign ex_alu_b      = ex_q.use_imm ? ex_q.imm : fwd_b;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_store_data = fwd_b;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_funct3     = ex_q.funct3;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_is_branch  = ex_q.is_branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases plus random traffic
// against an instruction-level model of the EX slot.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3, id_class;
  logic        id_funct7_5, id_reg_write, id_mem_read;
  logic        id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [63:0] exmem_result, memwb_wdata;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_is_branch, load_use_hazard;
  logic [63:0] ex_alu_a, ex_alu_b, ex_store_data, ex_pc;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_5(id_funct7_5), .id_class(id_class),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write),
    .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_wdata(memwb_wdata),
    .ex_valid(ex_valid), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_alu_op(ex_alu_op),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_is_branch(ex_is_branch),
    .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // model of the instruction sitting in EX
  bit          m_valid, m_f75, m_rw, m_mr, m_mw, m_m2r;
  int          m_cls, m_rs1, m_rs2, m_rd, m_f3;
  logic [63:0] m_pc, m_d1, m_d2, m_imm;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_f75 = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
    m_cls = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0;
    m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
  endtask

  task automatic model_edge();
    if (flush) model_reset();
    else if (stall) ;
    else if (!id_valid || id_class > 4) model_reset();
    else begin
      m_valid = 1; m_cls = id_class; m_f75 = id_funct7_5;
      m_f3 = id_funct3; m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_rd = id_rd; m_pc = id_pc; m_d1 = id_rs1_data;
      m_d2 = id_rs2_data; m_imm = id_imm; m_rw = id_reg_write;
      m_mr = id_mem_read; m_mw = id_mem_write;
      m_m2r = id_mem_to_reg;
    end
  endtask

  function automatic logic [63:0] fwd(int rs, logic [63:0] fd);
    if (exmem_reg_write && rs != 0 && exmem_rd == rs)
      return exmem_result;
    if (memwb_reg_write && rs != 0 && memwb_rd == rs)
      return memwb_wdata;
    return fd;
  endfunction

  function automatic int exp_op();
    case (m_cls)
      0: return (m_f75 ? 8 : 0) + m_f3;
      1: return ((m_f75 && m_f3 == 5) ? 8 : 0) + m_f3;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic check_all();
    bit hz;
    hz = m_valid && m_mr && m_rd != 0 && id_valid
      && (m_rd == id_rs1
       || (m_rd == id_rs2 && id_class != 1 && id_class != 2));
    chk("valid", ex_valid, m_valid);
    chk("reg_write", ex_reg_write, m_rw);
    chk("mem_read", ex_mem_read, m_mr);
    chk("mem_write", ex_mem_write, m_mw);
    chk("mem_to_reg", ex_mem_to_reg, m_m2r);
    chk("is_branch", ex_is_branch, m_valid && m_cls == 4);
    chk("hazard", load_use_hazard, hz);
    if (m_valid) begin
      chk("pc", ex_pc, m_pc);
      chk("rd", ex_rd, m_rd);
      chk("funct3", ex_funct3, m_f3);
      chk("alu_op", ex_alu_op, exp_op());
      chk("alu_a", ex_alu_a, fwd(m_rs1, m_d1));
      chk("alu_b", ex_alu_b,
          (m_cls >= 1 && m_cls <= 3) ? m_imm : fwd(m_rs2, m_d2));
      chk("store_data", ex_store_data, fwd(m_rs2, m_d2));
    end
  endtask

  task automatic check_zero(string tag);
    logic [63:0] all;
    all = ex_alu_a | ex_alu_b | ex_store_data | ex_pc
        | {ex_alu_op, ex_rd, ex_funct3, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_is_branch,
           load_use_hazard};
    chk(tag, all, 64'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(bit v, int cls, int f3, bit f75, int rs1,
                        int rs2, int rd, logic [63:0] d1,
                        logic [63:0] d2, logic [63:0] imm, bit rw,
                        bit mr, bit mw, bit m2r, logic [63:0] pc);
    id_valid = v; id_class = 3'(cls); id_funct3 = 3'(f3);
    id_funct7_5 = f75; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_rd = 5'(rd); id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw; id_mem_to_reg = m2r; id_pc = pc;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; memwb_reg_write = 0;
    exmem_rd = 0; memwb_rd = 0;
    exmem_result = 0; memwb_wdata = 0;
  endtask

  task automatic rnd_inputs();
    set_id($urandom_range(7) != 0, $urandom_range(7),
           $urandom_range(7), 1'($urandom), $urandom_range(7),
           $urandom_range(7), $urandom_range(7),
           {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), {$urandom, $urandom});
    stall = $urandom_range(4) == 0;
    flush = $urandom_range(7) == 0;
    exmem_reg_write = 1'($urandom); memwb_reg_write = 1'($urandom);
    exmem_rd = 5'($urandom_range(7));
    memwb_rd = 5'($urandom_range(7));
    exmem_result = {$urandom, $urandom};
    memwb_wdata = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    no_fwd();
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_zero("reset_state");
    rst = 0;

    // ADD x3,x1,x2 with 5/7
    set_id(1, 0, 0, 0, 1, 2, 3, 5, 7, 99, 1, 0, 0, 0, 64'h100);
    cycle();
    chk("add_op", ex_alu_op, 4'b0000);
    chk("add_a", ex_alu_a, 64'd5);
    chk("add_b", ex_alu_b, 64'd7);
    check_all();

    set_id(1, 1, 5, 1, 1, 0, 3, 9, 0, 3, 1, 0, 0, 0, 64'h104);
    cycle();
    chk("srai_op", ex_alu_op, 4'b1101);
    check_all();
    set_id(1, 1, 0, 1, 1, 0, 3, 9, 0, 64'h4000_0000, 1, 0, 0, 0, 64'h108);
    cycle();
    chk("addi_op", ex_alu_op, 4'b0000);
    chk("addi_b", ex_alu_b, 64'h4000_0000);
    set_id(1, 0, 0, 1, 1, 2, 3, 9, 4, 0, 1, 0, 0, 0, 64'h10c);
    cycle();
    chk("sub_op", ex_alu_op, 4'b1000);
    set_id(1, 4, 0, 0, 1, 2, 0, 9, 4, 64'h20, 0, 0, 0, 0, 64'h110);
    cycle();
    chk("beq_op", ex_alu_op, 4'b1000);
    chk("beq_b", ex_alu_b, 64'd4);
    chk("beq_br", ex_is_branch, 1'b1);

    // forwarding priority on rs1=x3
    set_id(1, 0, 0, 0, 3, 2, 5, 64'h11, 64'h22, 0, 1, 0, 0, 0, 64'h114);
    cycle();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 64'hAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_wdata = 64'hBB;
    #1 chk("fwd_exmem", ex_alu_a, 64'hAA);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", ex_alu_a, 64'hBB);
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    #1 chk("fwd_x0", ex_alu_a, 64'h11);
    check_all();
    no_fwd();

    // LD x4 in EX, then ADD x5,x4,x1 in ID
    set_id(1, 2, 3, 0, 1, 0, 4, 64'h8, 0, 64'h10, 1, 1, 0, 1, 64'h118);
    cycle();
    set_id(1, 0, 0, 0, 4, 1, 5, 0, 0, 0, 1, 0, 0, 0, 64'h11c);
    #1 chk("lu_hit", load_use_hazard, 1'b1);
    set_id(1, 0, 0, 0, 1, 2, 4, 0, 0, 0, 1, 0, 0, 0, 64'h11c);
    #1 chk("lu_rd_only", load_use_hazard, 1'b0);
    set_id(1, 1, 0, 0, 1, 4, 5, 0, 0, 0, 1, 0, 0, 0, 64'h11c);
    #1 chk("lu_itype_rs2", load_use_hazard, 1'b0);
    check_all();
    set_id(1, 2, 3, 0, 1, 0, 0, 64'h8, 0, 64'h10, 1, 1, 0, 1, 64'h120);
    cycle();
    set_id(1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0, 64'h124);
    #1 chk("lu_rd0", load_use_hazard, 1'b0);

    // stall holds for three cycles
    set_id(1, 0, 7, 0, 1, 2, 6, 64'h31, 64'h32, 0, 1, 0, 0, 0, 64'h200);
    cycle();
    stall = 1;
    set_id(1, 3, 2, 0, 5, 6, 7, 1, 2, 3, 0, 0, 1, 0, 64'h300);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", ex_pc, 64'h200);
      chk("stall_a", ex_alu_a, 64'h31);
      chk("stall_op", ex_alu_op, 4'b0111);
    end
    flush = 1;
    cycle();
    chk("flush_valid", ex_valid, 1'b0);
    chk("flush_rw", ex_reg_write, 1'b0);
    check_all();
    flush = 0; stall = 0;

    for (int i = 0; i < 400; i++) begin
      rnd_inputs();
      #1 check_all();
      cycle();
    end

    // asynchronous reset between edges
    stall = 0; flush = 0; no_fwd();
    set_id(1, 0, 1, 0, 1, 2, 3, 5, 6, 0, 1, 1, 1, 1, 64'h400);
    @(posedge clk);
    model_edge();
    #1 chk("pre_rst_valid", ex_valid, 1'b1);
    #2 rst = 1;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 0;
    stall = 1;
    #1 check_zero("post_rst");
    cycle();
    check_zero("post_rst_stall");
    stall = 0;
    cycle();
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
